// File: rtl/cache_line_fill_ctrl_if.sv
// Bundle between the miss sequencer (master) and the cache tag logic, data array
// and lower-level memory port (slave).
interface cache_line_fill_ctrl_if #(
    parameter int BEAT_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_dirty;
    logic [31:0]       req_victim_addr;
    logic              wb_rd_en;
    logic [BEAT_W-1:0] wb_beat;
    logic [31:0]       wb_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              fill_we;
    logic [BEAT_W-1:0] fill_beat;
    logic [31:0]       fill_data;
    logic              done;
    logic              busy;
    logic [31:0]       wb_count;
    logic [31:0]       fill_count;

    modport master (
        input  req_valid, req_addr, req_dirty, req_victim_addr, wb_rdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, wb_rd_en, wb_beat, mem_req, mem_we, mem_addr, mem_wdata,
               fill_we, fill_beat, fill_data, done, busy, wb_count, fill_count
    );

    modport slave (
        output req_valid, req_addr, req_dirty, req_victim_addr, wb_rdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, wb_rd_en, wb_beat, mem_req, mem_we, mem_addr, mem_wdata,
               fill_we, fill_beat, fill_data, done, busy, wb_count, fill_count
    );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Cache miss sequencer: optional dirty-victim writeback, then a beat-by-beat line
// fill into the data array, one line operation at a time, with saturating stats.
module cache_line_fill_ctrl #(
    parameter int LINE_SIZE  = 64,
    parameter int BEAT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_line_fill_ctrl_if.master bus
);
    localparam int BEATS    = LINE_SIZE / BEAT_BYTES;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WB, FILL_REQ, FILL_WAIT, DONE} state_t;

    state_t            state, state_d;
    logic [BEAT_W-1:0] beat, beat_d;
    logic [31:0]       miss_base, victim_base;
    logic [31:0]       wb_cnt, fill_cnt;
    logic [31:0]       beat_off;
    logic              accept, wb_inc, fill_inc;

    assign beat_off       = 32'(beat) * 32'(BEAT_BYTES);
    assign bus.busy       = (state != IDLE);
    assign bus.wb_count   = wb_cnt;
    assign bus.fill_count = fill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_d;
            beat  <= beat_d;
        end
    end

    // Line bases drop the byte offset so beats always start at offset 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_base   <= '0;
            victim_base <= '0;
        end else if (accept) begin
            miss_base   <= {bus.req_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            victim_base <= {bus.req_victim_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt   <= '0;
            fill_cnt <= '0;
        end else begin
            if (wb_inc && wb_cnt != 32'hFFFF_FFFF)     wb_cnt   <= wb_cnt + 32'd1;
            if (fill_inc && fill_cnt != 32'hFFFF_FFFF) fill_cnt <= fill_cnt + 32'd1;
        end
    end

    always_comb begin
        state_d       = state;
        beat_d        = beat;
        accept        = 1'b0;
        wb_inc        = 1'b0;
        fill_inc      = 1'b0;
        bus.req_ready = 1'b0;
        bus.wb_rd_en  = 1'b0;
        bus.wb_beat   = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.fill_we   = 1'b0;
        bus.fill_beat = '0;
        bus.fill_data = '0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    beat_d  = '0;
                    state_d = bus.req_dirty ? WB : FILL_REQ;
                end
            end
            WB: begin
                // Array read is combinational, so the beat is offered as write data directly.
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.wb_rd_en  = 1'b1;
                bus.wb_beat   = beat;
                bus.mem_addr  = victim_base + beat_off;
                bus.mem_wdata = bus.wb_rdata;
                if (bus.mem_gnt) begin
                    if (beat == LAST_BEAT) begin
                        beat_d  = '0;
                        wb_inc  = 1'b1;
                        state_d = FILL_REQ;
                    end else begin
                        beat_d = beat + 1'b1;
                    end
                end
            end
            FILL_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = miss_base + beat_off;
                if (bus.mem_gnt) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.mem_rvalid) begin
                    bus.fill_we   = 1'b1;
                    bus.fill_beat = beat;
                    bus.fill_data = bus.mem_rdata;
                    if (beat == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat + 1'b1;
                        state_d = FILL_REQ;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                fill_inc = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench for cache_line_fill_ctrl: stimulus queues expected beats/done,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_line_fill_ctrl;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] beat;} mem_t;
    typedef struct packed {logic [3:0] beat; logic [31:0] data;} fill_t;
    typedef struct packed {logic [31:0] lat; logic [31:0] wb; logic [31:0] fill;} done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    cache_line_fill_ctrl_if #(.BEAT_W(4)) bus();
    cache_line_fill_ctrl #(.LINE_SIZE(64), .BEAT_BYTES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0, dones = 0;
    mem_t  qm[$];
    fill_t qf[$];
    done_t qd[$];
    logic [31:0] exp_wb = 0, exp_fill = 0;

    // memory model: read data one cycle after grant, grant withheld on chosen beats
    logic        rv_q = 1'b0, spur_rv = 1'b0;
    logic [31:0] rd_q = '0, sa_w = '0, sa_r = '0;
    int          sl_w = 0, sl_r = 0;
    logic        stall_w, stall_r;
    assign stall_w = bus.mem_req && bus.mem_we && bus.mem_addr == sa_w && sl_w > 0;
    assign stall_r = bus.mem_req && !bus.mem_we && bus.mem_addr == sa_r && sl_r > 0;
    assign bus.mem_gnt    = !(stall_w || stall_r);
    assign bus.mem_rvalid = rv_q | spur_rv;
    assign bus.mem_rdata  = rd_q;
    assign bus.wb_rdata   = bus.wb_rd_en ? (32'hDA7A_0000 | 32'(bus.wb_beat)) : 32'h0;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rv_q <= bus.mem_req && bus.mem_gnt && !bus.mem_we;
        rd_q <= bus.mem_addr ^ 32'h5A5A_0000;
        if (stall_w) sl_w <= sl_w - 1;
        if (stall_r) sl_r <= sl_r - 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor
    mem_t m; fill_t f; done_t d, cnt_exp;
    logic cnt_pend = 1'b0, prev_stall = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            cnt_pend   = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
            if (prev_stall) begin
                chk("stall_addr", bus.mem_addr, p_addr);
                chk("stall_wdata", bus.mem_wdata, p_wdata);
                chk("stall_req_we", {30'b0, bus.mem_req, bus.mem_we}, {30'b0, 1'b1, p_we});
            end
            prev_stall = bus.mem_req && !bus.mem_gnt;
            p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_we = bus.mem_we;
            if (bus.mem_req && bus.mem_gnt) begin
                if (qm.size() == 0) chk("mem_unexpected", bus.mem_addr, 32'hxxxx_xxxx);
                else begin
                    m = qm.pop_front();
                    chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                    chk("mem_addr", bus.mem_addr, m.addr);
                    chk("wb_rd_en", 32'(bus.wb_rd_en), 32'(m.we));
                    if (m.we) begin
                        chk("mem_wdata", bus.mem_wdata, m.wdata);
                        chk("wb_beat", 32'(bus.wb_beat), 32'(m.beat));
                    end
                end
            end
            if (bus.fill_we) begin
                if (qf.size() == 0) chk("fill_unexpected", bus.fill_data, 32'hxxxx_xxxx);
                else begin
                    f = qf.pop_front();
                    chk("fill_beat", 32'(bus.fill_beat), 32'(f.beat));
                    chk("fill_data", bus.fill_data, f.data);
                end
            end
            if (cnt_pend) begin
                chk("wb_count", bus.wb_count, cnt_exp.wb);
                chk("fill_count", bus.fill_count, cnt_exp.fill);
                cnt_pend = 1'b0;
            end
            if (bus.done) begin
                dones++;
                if (qd.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    d = qd.pop_front();
                    chk("done_latency", 32'(cyc - acc_cyc), d.lat);
                    cnt_exp  = d;
                    cnt_pend = 1'b1;
                end
            end
        end
    end

    // queue expectations, then present the request and wait for acceptance
    task automatic issue(input logic [31:0] addr, input logic dirty, input logic [31:0] victim,
                         input int extra, input logic hold);
        mem_t mm; fill_t ff; done_t dd; int n;
        logic [31:0] mb, vb;
        mb = addr & 32'hFFFF_FFC0;
        vb = victim & 32'hFFFF_FFC0;
        if (dirty)
            for (int b = 0; b < 16; b++) begin
                mm.we = 1'b1; mm.addr = vb + 32'(4 * b); mm.wdata = 32'hDA7A_0000 | 32'(b); mm.beat = 4'(b);
                qm.push_back(mm);
            end
        for (int b = 0; b < 16; b++) begin
            mm.we = 1'b0; mm.addr = mb + 32'(4 * b); mm.wdata = '0; mm.beat = 4'(b);
            qm.push_back(mm);
            ff.beat = 4'(b); ff.data = (mb + 32'(4 * b)) ^ 32'h5A5A_0000;
            qf.push_back(ff);
        end
        if (dirty && exp_wb != 32'hFFFF_FFFF) exp_wb++;
        if (exp_fill != 32'hFFFF_FFFF) exp_fill++;
        dd.lat = 32'((dirty ? 49 : 33) + extra); dd.wb = exp_wb; dd.fill = exp_fill;
        qd.push_back(dd);
        bus.req_addr = addr; bus.req_dirty = dirty; bus.req_victim_addr = victim; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 400) begin @(negedge clk); n++; end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_dirty = 1'b0; bus.req_victim_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", {30'b0, bus.mem_req, bus.mem_we}, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_counts", bus.wb_count | bus.fill_count, 32'd0);

        // spurious rvalid in IDLE
        spur_rv = 1'b1; #1;
        chk("spur_idle_fill_we", 32'(bus.fill_we), 32'd0);
        @(posedge clk); #1;
        chk("spur_idle_busy", 32'(bus.busy), 32'd0);
        spur_rv = 1'b0;
        @(negedge clk);

        issue(32'h0000_1234, 1'b0, 32'h0, 0, 1'b0);               // clean miss
        wait_idle();
        issue(32'h0000_4040, 1'b1, 32'h0000_8000, 0, 1'b0);       // dirty miss
        wait_idle();

        // grant withheld 5 cycles on WB beat 3 and FILL_REQ beat 7
        sa_w = 32'h0000_900C; sl_w = 5; sa_r = 32'h0000_501C; sl_r = 5;
        issue(32'h0000_5013, 1'b1, 32'h0000_9005, 10, 1'b0);
        wait_idle();

        // req_valid held across a busy line, rvalid pulsed during WB
        d0 = dones;
        issue(32'h0000_6000, 1'b1, 32'h0000_A000, 0, 1'b1);
        @(negedge clk);
        spur_rv = 1'b1; #1;
        chk("spur_wb_fill_we", 32'(bus.fill_we), 32'd0);
        chk("spur_wb_mem_we", 32'(bus.mem_we), 32'd1);
        @(posedge clk); #1;
        spur_rv = 1'b0;
        @(negedge clk);
        issue(32'h0000_7008, 1'b0, 32'h0, 0, 1'b0);
        chk("held_accept_after_done", 32'(dones), 32'(d0 + 1));
        wait_idle();

        // reset during FILL_WAIT beat 9
        issue(32'h0000_2000, 1'b0, 32'h0, 0, 1'b0);
        begin
            int n = 0;
            while (!(bus.fill_we && bus.fill_beat == 4'd9) && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) chk("beat9_timeout", 32'd0, 32'd1);
        end
        #2 rst_n = 1'b0;
        qm.delete(); qf.delete(); qd.delete();
        exp_wb = 0; exp_fill = 0;
        d0 = dones;
        #1;
        chk("midrst_busy_ready", {30'b0, bus.busy, bus.req_ready}, 32'd1);
        chk("midrst_strobes", {28'b0, bus.mem_req, bus.fill_we, bus.done, bus.wb_rd_en}, 32'd0);
        chk("midrst_mem_addr", bus.mem_addr, 32'd0);
        chk("midrst_counts", bus.wb_count | bus.fill_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", 32'(dones), 32'(d0));
        issue(32'h0000_3000, 1'b0, 32'h0, 0, 1'b0);
        wait_idle();

        // counter saturation
        force dut.fill_cnt = 32'hFFFF_FFFE;
        #1 release dut.fill_cnt;
        exp_fill = 32'hFFFF_FFFE;
        chk("sat_preload", bus.fill_count, 32'hFFFF_FFFE);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(32'h0000_C000 + 32'(i * 64), 1'b0, 32'h0, 0, 1'b0);
            wait_idle();
        end
        chk("sat_final", bus.fill_count, 32'hFFFF_FFFF);
        chk("queues_empty", 32'(qm.size() + qf.size() + qd.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
